// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multicycle control unit for the 32-bit MIPS-subset datapath.
//               It decodes R-type add/sub/and, addi, lw, sw, beq, bne, j and
//               the reset opcode. It raises illegal-opcode/funct and overflow
//               exceptions, and counts memory wait states for instruction
//               fetch and lw reads.
//
// Ports       : clk, reset            - clock, synchronous active-high reset
//               opcode, funct         - IR[31:26], IR[5:0]
//               overflow, zero        - ALU flags
//               *_write strobes       - PC/mem/IR/A-B/regfile/ALUOut/MDR/EPC
//               alu_op, alu_src_a/b   - ALU operation and operand selects
//               pc_source, iord       - PC source and memory address selects
//               mem_to_reg, reg_dst   - register-file write data and address
//               exc_cause             - cause, shown during the EXCEPT cycle
//               rst_out, instr_done   - RESET indicator, last-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int         MEM_LAT      = 2,
    parameter logic [5:0] RESET_OPCODE = 6'h3F,
    parameter bit         EXC_OVF_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       pc_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic       ab_write,
    output logic       reg_write,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       epc_write,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] pc_source,
    output logic [2:0] iord,
    output logic [3:0] mem_to_reg,
    output logic [2:0] reg_dst,
    output logic [1:0] exc_cause,
    output logic       rst_out,
    output logic       instr_done
);

    localparam int            CW     = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(MEM_LAT - 1);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_j     = 6'h02;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_ovf     = 2'b10;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_EXEC_I = 4'd5,
        S_WB_I   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_LW  = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_EXCEPT = 4'd13
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    cause_q, cause_d;

    logic w_last;      // final wait-state cycle of FETCH / MEM_RD
    logic w_arith;     // R-type funct is add or sub (can overflow)
    logic w_illegal;   // R-type funct not supported

    assign w_last = (cnt_q == C_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;            // cleared everywhere else, so zero on entry
        cause_d      = c_cause_none;  // only survives while entering EXCEPT
        w_arith      = 1'b0;
        w_illegal    = 1'b0;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        reg_write    = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        epc_write    = 1'b0;
        alu_op       = 3'b000;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        pc_source    = 3'b000;
        iord         = 3'b000;
        mem_to_reg   = 4'b0000;
        reg_dst      = 3'b000;
        exc_cause    = 2'b00;
        rst_out      = 1'b0;
        instr_done   = 1'b0;

        case (state_q)
            S_RESET: begin
                // Stack pointer r29 is initialised to 227
                rst_out    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 4'b1000;
                reg_dst    = 3'b010;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                iord      = 3'b000;
                alu_src_a = 2'b00;
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                if (w_last) begin
                    pc_write  = 1'b1;
                    pc_source = 3'b000;
                    ir_write  = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ab_write     = 1'b1;
                aluout_write = 1'b1;
                alu_src_a    = 2'b00;
                alu_src_b    = 2'b11;
                alu_op       = 3'b001;
                case (opcode)
                    c_op_rtype:          state_d = S_EXEC_R;
                    c_op_addi:           state_d = S_EXEC_I;
                    c_op_lw, c_op_sw:    state_d = S_ADDR;
                    c_op_beq, c_op_bne:  state_d = S_BRANCH;
                    c_op_j:              state_d = S_JUMP;
                    default: begin
                        if (opcode == RESET_OPCODE) begin
                            state_d = S_RESET;
                        end else begin
                            state_d = S_EXCEPT;
                            cause_d = c_cause_illegal;
                        end
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b00;
                aluout_write = 1'b1;
                case (funct)
                    6'h20: begin alu_op = 3'b001; w_arith = 1'b1; end
                    6'h22: begin alu_op = 3'b010; w_arith = 1'b1; end
                    6'h24: alu_op = 3'b011;
                    default: w_illegal = 1'b1;
                endcase
                if (w_illegal) begin
                    state_d = S_EXCEPT;
                    cause_d = c_cause_illegal;
                end else if (w_arith && overflow && EXC_OVF_EN) begin
                    // Keep the overflowed result out of ALUOut
                    aluout_write = 1'b0;
                    state_d      = S_EXCEPT;
                    cause_d      = c_cause_ovf;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 3'b001;
                mem_to_reg = 4'b0000;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                alu_op       = 3'b001;
                aluout_write = 1'b1;
                if (overflow && EXC_OVF_EN) begin
                    aluout_write = 1'b0;
                    state_d      = S_EXCEPT;
                    cause_d      = c_cause_ovf;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                reg_dst    = 3'b000;
                mem_to_reg = 4'b0000;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                alu_op       = 3'b001;
                aluout_write = 1'b1;
                state_d      = (opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord = 3'b001;
                if (w_last) begin
                    mdr_write = 1'b1;
                    state_d   = S_WB_LW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                reg_dst    = 3'b000;
                mem_to_reg = 4'b0001;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord       = 3'b001;
                mem_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b00;
                alu_op     = 3'b010;
                pc_source  = 3'b001;
                instr_done = 1'b1;
                // Taken decision straight from the live zero flag
                pc_write   = (opcode == c_op_beq) ? zero : ~zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 3'b010;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXCEPT: begin
                // EPC <- PC - 4 (PC already advanced during fetch)
                epc_write  = 1'b1;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b01;
                alu_op     = 3'b010;
                pc_write   = 1'b1;
                pc_source  = 3'b011;
                instr_done = 1'b1;
                exc_cause  = cause_q;
                state_d    = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            cause_q <= c_cause_none;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Self-checking bench for mc_ctrl_fsm. Three instances with
//               different memory latency / overflow-enable settings. Each
//               instruction is expanded by an instruction-level model into
//               its expected per-cycle control words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam int N = 3;
    localparam int LAT [N] = '{2, 3, 1};
    localparam bit OVE [N] = '{1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic       pc_write, mem_write, ir_write, ab_write;
        logic       reg_write, aluout_write, mdr_write, epc_write;
        logic [2:0] alu_op;
        logic [1:0] alu_src_a, alu_src_b;
        logic [2:0] pc_source, iord;
        logic [3:0] mem_to_reg;
        logic [2:0] reg_dst;
        logic [1:0] exc_cause;
        logic       rst_out, instr_done;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_r [N];
    logic [5:0]  op_r  [N];
    logic [5:0]  fn_r  [N];
    logic        ovf_r [N];
    logic        z_r   [N];
    logic [31:0] obs   [N];

    int    checks   = 0;
    int    failures = 0;
    outs_t exp_q [$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            logic       pc_write, mem_write, ir_write, ab_write;
            logic       reg_write, aluout_write, mdr_write, epc_write;
            logic [2:0] alu_op, pc_source, iord, reg_dst;
            logic [1:0] alu_src_a, alu_src_b, exc_cause;
            logic [3:0] mem_to_reg;
            logic       rst_out, instr_done;

            mc_ctrl_fsm #(
                .MEM_LAT      (LAT[g]),
                .RESET_OPCODE (6'h3F),
                .EXC_OVF_EN   (OVE[g])
            ) u_dut (
                .clk          (clk),
                .reset        (rst_r[g]),
                .opcode       (op_r[g]),
                .funct        (fn_r[g]),
                .overflow     (ovf_r[g]),
                .zero         (z_r[g]),
                .pc_write     (pc_write),
                .mem_write    (mem_write),
                .ir_write     (ir_write),
                .ab_write     (ab_write),
                .reg_write    (reg_write),
                .aluout_write (aluout_write),
                .mdr_write    (mdr_write),
                .epc_write    (epc_write),
                .alu_op       (alu_op),
                .alu_src_a    (alu_src_a),
                .alu_src_b    (alu_src_b),
                .pc_source    (pc_source),
                .iord         (iord),
                .mem_to_reg   (mem_to_reg),
                .reg_dst      (reg_dst),
                .exc_cause    (exc_cause),
                .rst_out      (rst_out),
                .instr_done   (instr_done)
            );

            assign obs[g] = {pc_write, mem_write, ir_write, ab_write,
                             reg_write, aluout_write, mdr_write, epc_write,
                             alu_op, alu_src_a, alu_src_b, pc_source, iord,
                             mem_to_reg, reg_dst, exc_cause, rst_out, instr_done};
        end
    endgenerate

    // ---------------- instruction-level reference model ----------------
    function automatic outs_t reset_v();
        outs_t o = '0;
        o.rst_out    = 1'b1;
        o.reg_write  = 1'b1;
        o.mem_to_reg = 4'b1000;
        o.reg_dst    = 3'b010;
        return o;
    endfunction

    function automatic outs_t except_v(input logic [1:0] cause);
        outs_t o = '0;
        o.epc_write  = 1'b1;
        o.alu_src_b  = 2'b01;
        o.alu_op     = 3'b010;
        o.pc_write   = 1'b1;
        o.pc_source  = 3'b011;
        o.instr_done = 1'b1;
        o.exc_cause  = cause;
        return o;
    endfunction

    function automatic outs_t wb_v(input logic [2:0] dst, input logic [3:0] m2r);
        outs_t o = '0;
        o.reg_write  = 1'b1;
        o.reg_dst    = dst;
        o.mem_to_reg = m2r;
        o.instr_done = 1'b1;
        return o;
    endfunction

    task automatic push_instr(input int d, input logic [5:0] op, input logic [5:0] fn,
                              input bit ovf, input bit z);
        outs_t o;
        bit    legal, arith, ovf_exc;
        for (int i = 0; i < LAT[d]; i++) begin
            o = '0;
            o.alu_src_b = 2'b01;
            o.alu_op    = 3'b001;
            if (i == LAT[d] - 1) begin
                o.pc_write = 1'b1;
                o.ir_write = 1'b1;
            end
            exp_q.push_back(o);
        end
        o = '0;
        o.ab_write = 1'b1; o.aluout_write = 1'b1; o.alu_src_b = 2'b11; o.alu_op = 3'b001;
        exp_q.push_back(o);
        case (op)
            6'h00: begin
                legal   = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24);
                arith   = (fn == 6'h20) || (fn == 6'h22);
                ovf_exc = arith && ovf && OVE[d];
                o = '0;
                o.alu_src_a    = 2'b01;
                o.aluout_write = !ovf_exc;
                o.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                           (fn == 6'h24) ? 3'b011 : 3'b000;
                exp_q.push_back(o);
                if (!legal)       exp_q.push_back(except_v(2'b01));
                else if (ovf_exc) exp_q.push_back(except_v(2'b10));
                else              exp_q.push_back(wb_v(3'b001, 4'b0000));
            end
            6'h08: begin
                ovf_exc = ovf && OVE[d];
                o = '0;
                o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
                o.aluout_write = !ovf_exc;
                exp_q.push_back(o);
                if (ovf_exc) exp_q.push_back(except_v(2'b10));
                else         exp_q.push_back(wb_v(3'b000, 4'b0000));
            end
            6'h23, 6'h2B: begin
                o = '0;
                o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.alu_op = 3'b001;
                o.aluout_write = 1'b1;
                exp_q.push_back(o);
                if (op == 6'h23) begin
                    for (int i = 0; i < LAT[d]; i++) begin
                        o = '0;
                        o.iord      = 3'b001;
                        o.mdr_write = (i == LAT[d] - 1);
                        exp_q.push_back(o);
                    end
                    exp_q.push_back(wb_v(3'b000, 4'b0001));
                end else begin
                    o = '0;
                    o.iord = 3'b001; o.mem_write = 1'b1; o.instr_done = 1'b1;
                    exp_q.push_back(o);
                end
            end
            6'h04, 6'h05: begin
                o = '0;
                o.alu_src_a = 2'b01; o.alu_op = 3'b010; o.pc_source = 3'b001;
                o.instr_done = 1'b1;
                o.pc_write = (op == 6'h04) ? z : !z;
                exp_q.push_back(o);
            end
            6'h02: begin
                o = '0;
                o.pc_write = 1'b1; o.pc_source = 3'b010; o.instr_done = 1'b1;
                exp_q.push_back(o);
            end
            default: begin
                if (op == 6'h3F) exp_q.push_back(reset_v());
                else             exp_q.push_back(except_v(2'b01));
            end
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input int d, input outs_t e, input string tag, input int cyc);
        checks++;
        assert (obs[d] === e) else begin
            failures++;
            $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, cyc, obs[d], e);
        end
    endtask

    task automatic reset_session(input int d);
        rst_r[d] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check(d, reset_v(), "reset_hold", i);
        end
        rst_r[d] = 1'b0;
        check(d, reset_v(), "reset_release", 3);
    endtask

    // stop_at > 0: assert reset after that many cycles of the instruction
    task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn,
                       input bit ovf, input bit z, input int stop_at, input string tag);
        int n;
        op_r[d] = op; fn_r[d] = fn; ovf_r[d] = ovf; z_r[d] = z;
        exp_q.delete();
        push_instr(d, op, fn, ovf, z);
        n = (stop_at > 0) ? stop_at : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check(d, exp_q[i], tag, i);
        end
        if (stop_at > 0) begin
            rst_r[d] = 1'b1;
            @(posedge clk); #1;
            check(d, reset_v(), "abort_reset", 0);
            rst_r[d] = 1'b0;
        end
    endtask

    task automatic run_random(input int d, input int count);
        logic [5:0] ops [9];
        logic [5:0] fns [4];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h00};
        for (int k = 0; k < count; k++) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 3)];
            if (fn == 6'h00) fn = 6'($urandom);
            run(d, op, fn, 1'($urandom), 1'($urandom), 0, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_r[i] = 1'b1; op_r[i] = 6'h00; fn_r[i] = 6'h20;
            ovf_r[i] = 1'b0; z_r[i] = 1'b0;
        end

        // ---- MEM_LAT=2, overflow exceptions enabled ----
        reset_session(0);
        run(0, 6'h00, 6'h20, 1'b0, 1'b0, 0, "add");
        run(0, 6'h00, 6'h22, 1'b0, 1'b0, 0, "sub");
        run(0, 6'h00, 6'h24, 1'b0, 1'b0, 0, "and");
        run(0, 6'h04, 6'h00, 1'b0, 1'b1, 0, "beq_z1");
        run(0, 6'h05, 6'h00, 1'b0, 1'b1, 0, "bne_z1");
        run(0, 6'h08, 6'h00, 1'b1, 1'b0, 0, "addi_ovf");
        run(0, 6'h00, 6'h22, 1'b1, 1'b0, 0, "sub_ovf");
        run(0, 6'h00, 6'h24, 1'b1, 1'b0, 0, "and_ovf_ignored");
        run(0, 6'h00, 6'h25, 1'b0, 1'b0, 0, "bad_funct");
        run(0, 6'h3E, 6'h00, 1'b0, 1'b0, 0, "bad_opcode");
        run(0, 6'h3F, 6'h00, 1'b0, 1'b0, 0, "reset_opcode");
        run(0, 6'h02, 6'h00, 1'b0, 1'b0, 0, "jump");
        run(0, 6'h23, 6'h00, 1'b0, 1'b0, 5, "lw_abort");
        run(0, 6'h23, 6'h00, 1'b0, 1'b0, 0, "lw_after_abort");
        run(0, 6'h00, 6'h20, 1'b0, 1'b0, 2, "fetch_abort");
        run_random(0, 40);
        rst_r[0] = 1'b1;

        // ---- MEM_LAT=3, overflow ignored ----
        reset_session(1);
        run(1, 6'h23, 6'h00, 1'b0, 1'b0, 0, "lw3");
        run(1, 6'h2B, 6'h00, 1'b0, 1'b0, 0, "sw3");
        run(1, 6'h08, 6'h00, 1'b1, 1'b0, 0, "addi_ovf_off");
        run(1, 6'h00, 6'h20, 1'b1, 1'b0, 0, "add_ovf_off");
        run(1, 6'h23, 6'h00, 1'b0, 1'b0, 5, "lw3_abort_mid");
        run_random(1, 30);
        rst_r[1] = 1'b1;

        // ---- MEM_LAT=1 ----
        reset_session(2);
        run(2, 6'h23, 6'h00, 1'b0, 1'b0, 0, "lw1");
        run(2, 6'h2B, 6'h00, 1'b0, 1'b0, 0, "sw1");
        run(2, 6'h04, 6'h00, 1'b0, 1'b0, 0, "beq_z0");
        run(2, 6'h05, 6'h00, 1'b0, 1'b0, 0, "bne_z0");
        run_random(2, 30);
        rst_r[2] = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised multicycle control unit for the 32-bit MIPS-subset datapath. It replaces the fixed add-only sequencer with a decoded FSM covering R-type add/sub/and, addi, lw, sw, beq, bne, j, the reset opcode, and overflow/illegal-opcode exceptions. It adds a configurable memory wait-state counter. The block sits between the instruction register/ALU flags and every datapath mux select and write strobe.

## Interface
- MEM_LAT, 2: memory access latency in cycles, ≥1; applies to fetch and lw read.
- RESET_OPCODE, 6'h3F: opcode that re-enters the RESET state.
- EXC_OVF_EN, 1: 1 = add/sub/addi overflow raises an exception; 0 = overflow is ignored.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- overflow  in  1  ALU overflow flag
- zero  in  1  ALU zero flag
- pc_write, mem_write, ir_write, ab_write, reg_write, aluout_write, mdr_write, epc_write  out  1 each  write strobes
- alu_op  out  3  001 add, 010 sub, 011 and
- alu_src_a  out  2  00 PC, 01 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
- pc_source  out  3  000 ALU result, 001 ALUOut, 010 jump target, 011 exception vector
- iord  out  3  000 PC, 001 ALUOut
- mem_to_reg  out  4  0000 ALUOut, 0001 MDR, 1000 const 227
- reg_dst  out  3  000 rt, 001 rd, 010 r29
- exc_cause  out  2  00 none, 01 illegal opcode/funct, 10 overflow
- rst_out  out  1  high while in RESET
- instr_done  out  1  pulse on the last cycle of each instruction

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, WB_LW, MEM_WR, BRANCH, JUMP, EXCEPT.
- Any output not listed for a state is 0.
- RESET:
  - Asserts rst_out=1, reg_write=1, mem_to_reg=1000, reg_dst=010 (SP←227).
  - Next state is FETCH when reset=0.
- FETCH:
  - Asserts iord=000, alu_src_a=00, alu_src_b=01, alu_op=001 every cycle.
  - A wait counter holds FETCH for MEM_LAT cycles.
  - The last cycle adds pc_write=1 with pc_source=000, and ir_write=1.
  - Next state is DECODE.
- DECODE:
  - Asserts ab_write=1, aluout_write=1, alu_src_a=00, alu_src_b=11, alu_op=001 (branch target).
  - Dispatch on opcode:
    - 0x00 → EXEC_R
    - 0x08 → EXEC_I
    - 0x23 or 0x2B → ADDR
    - 0x04 or 0x05 → BRANCH
    - 0x02 → JUMP
    - RESET_OPCODE → RESET
    - anything else → EXCEPT with cause 01
- EXEC_R:
  - Asserts alu_src_a=01, alu_src_b=00, aluout_write=1.
  - alu_op from funct: 0x20→001, 0x22→010, 0x24→011.
  - Any other funct → EXCEPT with cause 01.
  - add/sub with overflow=1 and EXC_OVF_EN=1 → EXCEPT with cause 10, and aluout_write is suppressed.
  - Otherwise → WB_R.
- WB_R: reg_write=1, reg_dst=001, mem_to_reg=0000, instr_done=1 → FETCH.
- EXEC_I:
  - Same as EXEC_R but alu_src_b=10 and alu_op=001.
  - Same overflow rule; otherwise → WB_I.
- WB_I: reg_write=1, reg_dst=000, mem_to_reg=0000, instr_done=1 → FETCH.
- ADDR:
  - Asserts alu_src_a=01, alu_src_b=10, alu_op=001, aluout_write=1.
  - lw → MEM_RD; sw → MEM_WR.
- MEM_RD: iord=001 for MEM_LAT cycles; mdr_write=1 on the last cycle → WB_LW.
- WB_LW: reg_write=1, reg_dst=000, mem_to_reg=0001, instr_done=1 → FETCH.
- MEM_WR: one cycle of iord=001, mem_write=1, instr_done=1 → FETCH.
- BRANCH:
  - Asserts alu_src_a=01, alu_src_b=00, alu_op=010, pc_source=001, instr_done=1.
  - pc_write = zero for beq, !zero for bne. This is a Mealy output.
  - → FETCH.
- JUMP: pc_write=1, pc_source=010, instr_done=1 → FETCH.
- EXCEPT:
  - Asserts epc_write=1 with alu_src_a=00, alu_src_b=01, alu_op=010 (EPC←PC−4).
  - Asserts pc_write=1, pc_source=011, instr_done=1.
  - exc_cause holds the latched cause for this cycle only → FETCH.
- exc_cause is registered: latched on entry to EXCEPT and cleared on exit.

## Timing
- Single clock; state, wait counter and latched cause update on the rising edge of clk.
- Outputs decode combinationally from the current state, plus counter, zero and overflow where noted.
- Reset:
  - reset=1 at an edge forces state=RESET, counter=0, cause=00, from any state including mid-MEM_RD or mid-FETCH.
  - The following cycle shows only the RESET outputs.
  - Holding reset keeps the FSM in RESET.
  - Execution resumes with FETCH one cycle after reset deasserts.
- Instruction latencies:
  - R-type, addi, sw: MEM_LAT+3 cycles
  - lw: 2·MEM_LAT+3
  - beq, bne, j: MEM_LAT+2
  - Exception from DECODE: MEM_LAT+2
  - Exception from EXEC: MEM_LAT+3
- The wait counter is log2(MEM_LAT)+1 bits, reset to 0 on entry to FETCH/MEM_RD, with no wrap past MEM_LAT−1.
- MEM_LAT=1: FETCH and MEM_RD last one cycle, with the strobes on that cycle.

## Test plan
- Reset for 3 cycles, then release → rst_out=1 and reg_write=1 with mem_to_reg=1000, reg_dst=010; first FETCH pc_write+ir_write pulse at cycle MEM_LAT after RESET.
- MEM_LAT=2: add, sub, and sequence → each instr_done 5 cycles apart; EXEC alu_op 001/010/011; WB reg_dst=001.
- lw then sw, MEM_LAT=3 → lw: mdr_write on the 3rd MEM_RD cycle, instr_done at cycle 9; sw: single mem_write with iord=001, instr_done at cycle 6.
- beq with zero=1, then bne with zero=1 → pc_write=1 with pc_source=001 for beq only; each instruction takes 4 cycles.
- addi with overflow=1 → no reg_write; EXCEPT asserts epc_write, pc_write, pc_source=011, exc_cause=10. Same with EXC_OVF_EN=0 → WB_I reg_write=1 and no exception.
- Opcode 0x3E → EXCEPT with cause 01. Opcode 0x3F → RESET state. reset asserted during MEM_RD → next cycle in RESET, with no mdr_write or reg_write from the lw.
